// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle And/Or/Add/Sub with registered result and zero flag,
// plus an iterative radix-2 shift-add multiplier that holds busy_o for WIDTH cycles.
module alu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ctrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  localparam logic [2:0] CtrlAnd = 3'b000;
  localparam logic [2:0] CtrlOr  = 3'b001;
  localparam logic [2:0] CtrlAdd = 3'b010;
  localparam logic [2:0] CtrlMul = 3'b011;
  localparam logic [2:0] CtrlSub = 3'b110;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] acc_next;

  // Single-cycle datapath; undefined codes yield zero.
  always_comb begin
    op_res = '0;
    case (ctrl_i)
      CtrlAnd: op_res = data1_i & data2_i;
      CtrlOr:  op_res = data1_i | data2_i;
      CtrlAdd: op_res = data1_i + data2_i;
      CtrlSub: op_res = data1_i - data2_i;
      default: op_res = '0;
    endcase
  end

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (ctrl_i == CtrlMul) begin
            mcand_d  = data1_i;
            mplier_d = data2_i;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = StMul;
          end else begin
            result_d = op_res;
            zero_d   = (op_res == '0);
            valid_d  = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Final iteration: publish the sum including this iteration's add.
        if (cnt_q == LastCnt) begin
          result_d = acc_next;
          zero_d   = (acc_next == '0);
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign valid_o  = valid_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed vector table, reset/back-to-back
// sequences, and random operations against a plain-arithmetic reference model.
module tb_alu_iter;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   ctrl;
  logic [W-1:0] data1;
  logic [W-1:0] data2;
  logic [W-1:0] result;
  logic         zero;
  logic         valid;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_iter #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .ctrl_i  (ctrl),
    .data1_i (data1),
    .data2_i (data2),
    .result_o(result),
    .zero_o  (zero),
    .valid_o (valid),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           perturb;
    logic [W-1:0] res;
    logic         z;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Reference: product taken at double width and truncated.
  function automatic logic [W-1:0] ref_alu(input logic [2:0] c, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] p;
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b011: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return p[W-1:0];
      end
      3'b110:  return a - b;
      default: return '0;
    endcase
  endfunction

  // Issues one op at a negedge; returns in the cycle where valid_o is expected.
  task automatic run_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit perturb, output int nbusy, output bit stray);
    start = 1'b1;
    ctrl  = c;
    data1 = a;
    data2 = b;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    stray = 1'b0;
    while (busy && nbusy < 100) begin
      if (valid) stray = 1'b1;
      nbusy++;
      if (perturb) begin
        start = 1'b1;
        ctrl  = 3'($urandom);
        data1 = $urandom;
        data2 = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic [2:0] c, input logic [W-1:0] exp_res,
                          input logic exp_z, input int nbusy, input bit stray);
    check({tag, " valid"}, W'(valid), W'(1));
    check({tag, " result"}, result, exp_res);
    check({tag, " zero"}, W'(zero), W'(exp_z));
    check({tag, " busy_cycles"}, W'(nbusy), (c == 3'b011) ? W'(W) : W'(0));
    check({tag, " stray_valid"}, W'(stray), W'(0));
  endtask

  vec_t vecs[$];
  int   nb;
  bit   st;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ctrl  = '0;
    data1 = '0;
    data2 = '0;

    vecs.push_back('{3'b010, 32'd7,        32'd5,        1'b0, 32'd12,       1'b0});
    vecs.push_back('{3'b110, 32'd5,        32'd5,        1'b0, 32'd0,        1'b1});
    vecs.push_back('{3'b110, 32'd3,        32'd5,        1'b0, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd0,        1'b1});
    vecs.push_back('{3'b000, 32'h0000F0F0, 32'h0000FF00, 1'b0, 32'h0000F000, 1'b0});
    vecs.push_back('{3'b001, 32'h0000F0F0, 32'h0000FF00, 1'b0, 32'h0000FFF0, 1'b0});
    vecs.push_back('{3'b111, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'd0,        1'b1});
    vecs.push_back('{3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0,        1'b1});
    vecs.push_back('{3'b101, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'd0,        1'b1});
    vecs.push_back('{3'b011, 32'd6,        32'd7,        1'b1, 32'd42,       1'b0});
    vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1,        1'b0});
    vecs.push_back('{3'b011, 32'h00010000, 32'h00010000, 1'b0, 32'd0,        1'b1});
    vecs.push_back('{3'b011, 32'd3,        32'd4,        1'b0, 32'd12,       1'b0});
    vecs.push_back('{3'b010, 32'd2,        32'd2,        1'b0, 32'd4,        1'b0});

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset result", result, '0);
    check("reset zero", W'(zero), W'(1));
    check("reset valid", W'(valid), W'(0));
    check("reset busy", W'(busy), W'(0));
    @(negedge clk);
    check("idle valid", W'(valid), W'(0));

    // Entries issue back to back, so Mul 3x4 then Add 2+2 gives two adjacent valid cycles.
    foreach (vecs[i]) begin
      run_op(vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].perturb, nb, st);
      check_op($sformatf("vec%0d", i), vecs[i].c, vecs[i].res, vecs[i].z, nb, st);
    end
    @(negedge clk);
    check("valid_drop", W'(valid), W'(0));
    check("valid_drop result_held", result, 32'd4);

    // Reset mid-Mul aborts with no completion pulse.
    start = 1'b1; ctrl = 3'b011; data1 = 32'd1234; data2 = 32'd5678;
    @(negedge clk);
    start = 1'b0;
    check("rstmul busy_started", W'(busy), W'(1));
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmul busy", W'(busy), W'(0));
    check("rstmul result", result, '0);
    check("rstmul zero", W'(zero), W'(1));
    check("rstmul valid", W'(valid), W'(0));
    st = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid || busy) st = 1'b1;
    end
    check("rstmul no_late_valid", W'(st), W'(0));
    run_op(3'b010, 32'd1, 32'd1, 1'b0, nb, st);
    check_op("post_rst_add", 3'b010, 32'd2, 1'b0, nb, st);
    @(negedge clk);

    // Random operations against the reference model, with occasional idle gaps.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]   c;
      logic [W-1:0] a, b;
      logic [W-1:0] er;
      int unsigned  pick;
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1:    c = 3'b010;
        2, 3:    c = 3'b110;
        4:       c = 3'b000;
        5:       c = 3'b001;
        6, 7:    c = 3'b011;
        default: c = 3'($urandom_range(4, 7));
      endcase
      if ($urandom_range(0, 3) == 0) begin
        a = W'($urandom_range(0, 3));
        b = W'($urandom_range(0, 3));
      end else begin
        a = $urandom;
        b = $urandom;
      end
      er = ref_alu(c, a, b);
      run_op(c, a, b, ($urandom_range(0, 1) == 1), nb, st);
      check_op($sformatf("rand%0d c=%b a=%h b=%h", i, c, a, b), c, er, (er == '0), nb, st);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
# alu_iter

Execute-stage ALU for the pipelined MIPS core, directly downstream of the ALU control decoder: it consumes the 3-bit ALU control code and the two operands and produces a registered result and zero flag. And/Or/Add/Sub complete in one cycle. Mul runs as an iterative radix-2 shift-add multiplier over WIDTH cycles, and asserts busy_o so the hazard unit stalls the pipeline.

## Interface
- WIDTH, 32: operand/result width; also the Mul iteration count.

- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset; one clock, synchronous and active-high.
- start_i  input  1  operation request, sampled only when idle.
- ctrl_i  input  3  ALU control: 000 And, 001 Or, 010 Add, 011 Mul, 110 Sub.
- data1_i  input  WIDTH  operand A.
- data2_i  input  WIDTH  operand B.
- result_o  output  WIDTH  registered result; held until next completion.
- zero_o  output  1  registered, equals (result_o == 0).
- valid_o  output  1  one-cycle pulse: result_o/zero_o just updated.
- busy_o  output  1  registered; high while a Mul is in progress.

## Operation
- States: IDLE, MUL. Internal registers: mcand (WIDTH), mplier (WIDTH), acc (WIDTH), cnt (log2(WIDTH)+1 bits).
- IDLE, start_i=1, ctrl_i not Mul: at that edge load result_o with the op result, update zero_o, set valid_o=1; remain IDLE.
- Arithmetic: Add = data1_i+data2_i mod 2^WIDTH; Sub = data1_i−data2_i mod 2^WIDTH; And/Or bitwise; no carry/overflow outputs.
- Undefined codes (100, 101, 111): result_o=0, zero_o=1, valid_o pulses as for a normal op.
- IDLE, start_i=1, ctrl_i=Mul: latch mcand=data1_i, mplier=data2_i, acc=0, cnt=0; go MUL; busy_o=1.
- Each MUL cycle performs one iteration:
  - if mplier[0], acc += mcand (mod 2^WIDTH);
  - then mcand <<= 1, mplier >>= 1, cnt++.
- When the iteration with cnt==WIDTH-1 completes, load result_o with the final acc value (including that iteration's add), update zero_o, pulse valid_o, clear busy_o, return to IDLE — all at the same edge.
- Mul result is the low WIDTH bits of the product, which is identical for signed and unsigned operands. There is no early termination; latency is fixed.
- start_i, ctrl_i and data inputs are ignored in MUL; operands changing mid-Mul have no effect.
- valid_o is low in every cycle that is not a completion.

## Timing
- Reset values: result_o=0, zero_o=1, valid_o=0, busy_o=0, state IDLE, internal registers 0.
- Reset has priority over everything. Reset mid-Mul aborts it: no valid_o, result_o=0.
- Single-cycle ops: start sampled at edge E0; valid_o high in the cycle after E0.
- Mul: start sampled at E0; busy_o high after E0 through E_WIDTH (WIDTH cycles); iterations at E1..E_WIDTH; valid_o high and busy_o low after E_WIDTH.
- Back-to-back: a start in the cycle valid_o is high is accepted (state is IDLE). Consecutive single-cycle ops produce valid_o every cycle.
- busy_o depends on registered state only, with no combinational path from start_i, so the hazard unit sees the stall one cycle after Mul issue. Upstream holds start_i low or repeats it; repeats during MUL are dropped.

## Test plan
- Add 7+5, start one cycle -> next cycle result_o=12, zero_o=0, valid_o=1 for exactly one cycle, busy_o=0 throughout.
- Sub 5−5 -> result_o=0, zero_o=1; then Sub 3−5 -> result_o=0xFFFFFFFE; then Add 0xFFFFFFFF+1 -> 0, zero_o=1.
- And 0x0000F0F0 & 0x0000FF00 -> 0x0000F000; Or of the same operands -> 0x0000FFF0; ctrl 3'b111 -> result_o=0, valid_o pulses.
- Mul 6×7 with operands changed and start_i re-pulsed during busy -> busy_o high exactly 32 cycles, valid_o one cycle later, result_o=42. Mul 0xFFFFFFFF×0xFFFFFFFF -> 1; Mul 0x10000×0x10000 -> 0, zero_o=1.
- Reset asserted during Mul iteration 10 -> next cycle busy_o=0, result_o=0, zero_o=1, no valid_o; subsequent Add 1+1 -> 2 after one cycle.
- Mul 3×4 followed by Add 2+2 issued in the valid_o cycle -> valid_o high two consecutive cycles, result_o=12 then 4.
